svc_sram_arbiter: RTL
=====================

Name: svc_sram_arbiter

Overview:
- Round-robin arbiter that shares one SRAM command/read-response port among NUM_M requesters, e.g. several svc_axi_sram_if instances in front of a single svc_model_sram or SRAM controller.
- Each granted command is registered and tagged with the requester index in the upper meta bits.
- Read responses are demultiplexed back to the issuing requester using that tag.

Parameters:
- NUM_M, 2: number of requesters (2..8).
- SRAM_ADDR_WIDTH, 15: word address width.
- SRAM_DATA_WIDTH, 16: data width; strobe width is SRAM_DATA_WIDTH/8.
- META_WIDTH, 5: per-requester meta width.
- IDX_W, $clog2(NUM_M) (minimum 1): tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_cmd_valid  in  NUM_M  per-requester command valid.
- s_cmd_ready  out  NUM_M  per-requester command ready.
- s_cmd_wr_en  in  NUM_M  per-requester write enable.
- s_cmd_addr  in  NUM_M*SRAM_ADDR_WIDTH  packed addresses; requester i occupies slice i.
- s_cmd_meta  in  NUM_M*META_WIDTH  packed meta.
- s_cmd_wr_data  in  NUM_M*SRAM_DATA_WIDTH  packed write data.
- s_cmd_wr_strb  in  NUM_M*SRAM_DATA_WIDTH/8  packed strobes.
- s_rd_resp_valid  out  NUM_M  per-requester read response valid.
- s_rd_resp_ready  in  NUM_M  per-requester read response ready.
- s_rd_resp_data  out  SRAM_DATA_WIDTH  broadcast response data.
- s_rd_resp_meta  out  META_WIDTH  broadcast response meta (tag stripped).
- m_sram_cmd_valid / m_sram_cmd_ready  out / in  1  downstream command handshake.
- m_sram_cmd_wr_en  out  1.
- m_sram_cmd_addr  out  SRAM_ADDR_WIDTH.
- m_sram_cmd_meta  out  META_WIDTH+IDX_W  {tag, requester meta}.
- m_sram_cmd_wr_data  out  SRAM_DATA_WIDTH.
- m_sram_cmd_wr_strb  out  SRAM_DATA_WIDTH/8.
- m_sram_rd_resp_valid / m_sram_rd_resp_ready  in / out  1  downstream read response handshake.
- m_sram_rd_resp_data  in  SRAM_DATA_WIDTH.
- m_sram_rd_resp_meta  in  META_WIDTH+IDX_W.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: m_sram_cmd_valid=0, all registered command fields=0, rr_ptr=0, grant counters=0.
- Load condition: load = !m_sram_cmd_valid || m_sram_cmd_ready. The output register accepts a new command only when load is high.
- Winner selection: combinational. Winner is the first i with s_cmd_valid[i], scanning i = rr_ptr, rr_ptr+1, … modulo NUM_M.
- s_cmd_ready[i] = load && winner_valid && (winner==i). At most one ready bit is high per cycle. Ready never depends on the output register's own next-state.
- On a load with a winner:
  - register the winner's wr_en, addr, wr_data and wr_strb;
  - set m_sram_cmd_meta = {winner, s_cmd_meta[winner]};
  - set m_sram_cmd_valid=1;
  - set rr_ptr = (winner+1) mod NUM_M.
- On a load with no winner: m_sram_cmd_valid=0 and rr_ptr is unchanged.
- Stall stability: while m_sram_cmd_valid && !m_sram_cmd_ready, all m_sram_cmd_* outputs hold stable.
- Latency: 1 cycle from s-side handshake to m_sram_cmd_valid. Throughput: 1 command/cycle when m_sram_cmd_ready is held high.
- Fairness: with all requesters continuously valid, grants rotate strictly 0,1,…,NUM_M-1. No requester waits more than NUM_M-1 grants.
- Response routing (purely combinational, no state):
  - tag = m_sram_rd_resp_meta[META_WIDTH+:IDX_W];
  - s_rd_resp_valid[i] = m_sram_rd_resp_valid && tag==i;
  - m_sram_rd_resp_ready = s_rd_resp_ready[tag];
  - s_rd_resp_data and s_rd_resp_meta are broadcast, with meta = lower META_WIDTH bits.
- Out-of-range tag (possible only when NUM_M is not a power of 2): m_sram_rd_resp_ready=1 and the beat is dropped.
- Ordering: responses return in SRAM order, so no reorder buffer is needed.
- Reset mid-operation: a pending command is discarded (valid clears asynchronously). The response path keeps routing by tag during and after reset.

Optional Feature:
- Macro SVC_SRAM_ARB_STATS_EN.
- When defined: adds output port grant_cnt, NUM_M*16 bits.
  - Per-requester counter increments on each s-side handshake.
  - Saturates at 16'hFFFF.
  - Clears on reset.
- When undefined: port and counters absent; behaviour otherwise identical.

Test Plan:
- Idle after reset: m_sram_cmd_valid=0, s_cmd_ready=0, s_rd_resp_valid=0.
- Single requester: requester 1 issues write addr 0x5000, data 0xD000, meta 0x3, with m_sram_cmd_ready=1.
  - s_cmd_ready[1]=1 in the same cycle.
  - Next cycle: m_sram_cmd_valid=1, addr 0x5000, meta {1,0x3}, data 0xD000.
- Contention: both requesters hold valid for 4 cycles with ready=1 → grant order 0,1,0,1; each s_cmd_ready pulse is one-hot.
- Backpressure: m_sram_cmd_ready=0 for 3 cycles with requester 0 pending → outputs held stable; s_cmd_ready=0; first command issues when ready rises.
- Read routing: two reads, requester 0 addr 0x10 and requester 1 addr 0x20, against svc_model_sram.
  - Responses arrive with s_rd_resp_valid = 01 then 10.
  - Data equals the model's address-derived data; meta matches the original.
  - Holding s_rd_resp_ready[1]=0 stalls m_sram_rd_resp_ready.
- Reset mid-stall: assert rst_n=0 while m_sram_cmd_valid=1 → valid clears immediately (asynchronously); after release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/svc_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM command/read-response port among NUM_M requesters.
// Optional per-requester grant counters on port grant_cnt when SVC_SRAM_ARB_STATS_EN is defined.
module svc_sram_arbiter #(
   parameter int NUM_M           = 2,
   parameter int SRAM_ADDR_WIDTH = 15,
   parameter int SRAM_DATA_WIDTH = 16,
   parameter int META_WIDTH      = 5,
   parameter int IDX_W           = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_M-1:0]                       s_cmd_valid,
   output logic [NUM_M-1:0]                       s_cmd_ready,
   input  logic [NUM_M-1:0]                       s_cmd_wr_en,
   input  logic [NUM_M*SRAM_ADDR_WIDTH-1:0]       s_cmd_addr,
   input  logic [NUM_M*META_WIDTH-1:0]            s_cmd_meta,
   input  logic [NUM_M*SRAM_DATA_WIDTH-1:0]       s_cmd_wr_data,
   input  logic [NUM_M*(SRAM_DATA_WIDTH/8)-1:0]   s_cmd_wr_strb,
   output logic [NUM_M-1:0]                       s_rd_resp_valid,
   input  logic [NUM_M-1:0]                       s_rd_resp_ready,
   output logic [SRAM_DATA_WIDTH-1:0]             s_rd_resp_data,
   output logic [META_WIDTH-1:0]                  s_rd_resp_meta,
   output logic                                   m_sram_cmd_valid,
   input  logic                                   m_sram_cmd_ready,
   output logic                                   m_sram_cmd_wr_en,
   output logic [SRAM_ADDR_WIDTH-1:0]             m_sram_cmd_addr,
   output logic [META_WIDTH+IDX_W-1:0]            m_sram_cmd_meta,
   output logic [SRAM_DATA_WIDTH-1:0]             m_sram_cmd_wr_data,
   output logic [SRAM_DATA_WIDTH/8-1:0]           m_sram_cmd_wr_strb,
   input  logic                                   m_sram_rd_resp_valid,
   output logic                                   m_sram_rd_resp_ready,
   input  logic [SRAM_DATA_WIDTH-1:0]             m_sram_rd_resp_data,
   input  logic [META_WIDTH+IDX_W-1:0]            m_sram_rd_resp_meta
`ifdef SVC_SRAM_ARB_STATS_EN
   ,
   output logic [NUM_M*16-1:0]                    grant_cnt
`endif
);

   localparam int STRB_W = SRAM_DATA_WIDTH / 8;
   localparam int SCAN_W = IDX_W + 1;

   logic                        r_cmd_valid;
   logic                        r_cmd_wr_en;
   logic [SRAM_ADDR_WIDTH-1:0]  r_cmd_addr;
   logic [META_WIDTH+IDX_W-1:0] r_cmd_meta;
   logic [SRAM_DATA_WIDTH-1:0]  r_cmd_wr_data;
   logic [STRB_W-1:0]           r_cmd_wr_strb;
   logic [IDX_W-1:0]            r_rr_ptr;

   logic                        w_load;
   logic                        w_winner_valid;
   logic [IDX_W-1:0]            w_winner;
   logic [SCAN_W-1:0]           w_scan;
   logic [IDX_W-1:0]            w_tag;
   logic [NUM_M-1:0]            w_tag_match;

   logic [SRAM_ADDR_WIDTH-1:0]  w_addr    [NUM_M];
   logic [META_WIDTH-1:0]       w_meta    [NUM_M];
   logic [SRAM_DATA_WIDTH-1:0]  w_wr_data [NUM_M];
   logic [STRB_W-1:0]           w_wr_strb [NUM_M];

   assign w_load = !r_cmd_valid || m_sram_cmd_ready;
   assign w_tag  = m_sram_rd_resp_meta[META_WIDTH +: IDX_W];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_M; gi++) begin : g_req
         assign w_addr[gi]    = s_cmd_addr[gi*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
         assign w_meta[gi]    = s_cmd_meta[gi*META_WIDTH +: META_WIDTH];
         assign w_wr_data[gi] = s_cmd_wr_data[gi*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
         assign w_wr_strb[gi] = s_cmd_wr_strb[gi*STRB_W +: STRB_W];

         assign s_cmd_ready[gi]     = w_load && w_winner_valid && (w_winner == IDX_W'(gi));
         assign w_tag_match[gi]     = (w_tag == IDX_W'(gi));
         assign s_rd_resp_valid[gi] = m_sram_rd_resp_valid && w_tag_match[gi];
      end
   endgenerate

   // Scan requesters starting at the round-robin pointer, wrapping modulo NUM_M.
   always_comb begin
      w_winner_valid = 1'b0;
      w_winner       = '0;
      w_scan         = '0;
      for (int k = 0; k < NUM_M; k++) begin
         w_scan = {1'b0, r_rr_ptr} + SCAN_W'(k);
         if (w_scan >= SCAN_W'(NUM_M))
            w_scan = w_scan - SCAN_W'(NUM_M);
         if (!w_winner_valid && s_cmd_valid[w_scan[IDX_W-1:0]]) begin
            w_winner_valid = 1'b1;
            w_winner       = w_scan[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_valid   <= 1'b0;
         r_cmd_wr_en   <= 1'b0;
         r_cmd_addr    <= '0;
         r_cmd_meta    <= '0;
         r_cmd_wr_data <= '0;
         r_cmd_wr_strb <= '0;
         r_rr_ptr      <= '0;
      end else if (w_load) begin
         if (w_winner_valid) begin
            r_cmd_valid   <= 1'b1;
            r_cmd_wr_en   <= s_cmd_wr_en[w_winner];
            r_cmd_addr    <= w_addr[w_winner];
            r_cmd_meta    <= {w_winner, w_meta[w_winner]};
            r_cmd_wr_data <= w_wr_data[w_winner];
            r_cmd_wr_strb <= w_wr_strb[w_winner];
            r_rr_ptr      <= (w_winner == IDX_W'(NUM_M-1)) ? '0 : w_winner + 1'b1;
         end else begin
            r_cmd_valid <= 1'b0;
         end
      end
   end

   assign m_sram_cmd_valid   = r_cmd_valid;
   assign m_sram_cmd_wr_en   = r_cmd_wr_en;
   assign m_sram_cmd_addr    = r_cmd_addr;
   assign m_sram_cmd_meta    = r_cmd_meta;
   assign m_sram_cmd_wr_data = r_cmd_wr_data;
   assign m_sram_cmd_wr_strb = r_cmd_wr_strb;

   // A tag matching no requester is accepted and dropped so the SRAM never stalls on it.
   assign m_sram_rd_resp_ready = ~(|w_tag_match) | (|(w_tag_match & s_rd_resp_ready));
   assign s_rd_resp_data       = m_sram_rd_resp_data;
   assign s_rd_resp_meta       = m_sram_rd_resp_meta[META_WIDTH-1:0];

`ifdef SVC_SRAM_ARB_STATS_EN
   generate
      for (gi = 0; gi < NUM_M; gi++) begin : g_stats
         logic [15:0] r_grant_cnt;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_grant_cnt <= '0;
            else if (s_cmd_valid[gi] && s_cmd_ready[gi] && r_grant_cnt != 16'hFFFF)
               r_grant_cnt <= r_grant_cnt + 16'd1;
         end
         assign grant_cnt[gi*16 +: 16] = r_grant_cnt;
      end
   endgenerate
`endif

endmodule
